uart_frame_tx: RTL

Packetiser that sits directly upstream of the byte-level UART transmitter. On a start strobe it captures N_WORDS telemetry words from the vector-control core (currents, speed, angle) and emits a framed byte stream to the transmitter. Each byte is passed with a one-cycle enable pulse, paced by the transmitter's ready (send) flag. Frame: SYNC, LEN, payload bytes (MSB first per word), CHK.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_chk.sv | 35 +++
 rtl/uart_frame_tx.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART telemetry framer.
// Holds the FSM state enum, the default SYNC byte, frame sizing and the CRC-8 step.
package uart_frame_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT} state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int frame_len_bytes(input int n_words, input int word_w);
    return 3 + n_words * word_w / 8;
  endfunction

  // CRC-8, poly 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_chk.sv
// Frame checksum accumulator: additive mod-256 by default, CRC-8/0x07 when
// UART_FRAME_CRC8_EN is defined.
module uart_frame_chk
  import uart_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] byte_i,
  output logic [7:0] chk_o
);

  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clr) chk_d = 8'h00;
    else if (en) begin
`ifdef UART_FRAME_CRC8_EN
      chk_d = crc8_upd(chk_q, byte_i);
`else
      chk_d = chk_q + byte_i;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= 8'h00;
    else     chk_q <= chk_d;
  end

  assign chk_o = chk_q;

endmodule

// File: rtl/uart_frame_tx.sv
// Telemetry packetiser: snapshots N_WORDS words and streams SYNC, LEN, payload, CHK
// to a byte UART, one tx_en strobe per byte. CHK type selected by UART_FRAME_CRC8_EN.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int          N_WORDS   = 4,
  parameter int          WORD_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_WORDS*WORD_W-1:0] words_in,
  input  logic                      tx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_en,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int              NPAY  = N_WORDS * WORD_W / 8;
  localparam int              BPW   = WORD_W / 8;
  localparam int              NB    = frame_len_bytes(N_WORDS, WORD_W);
  localparam int              IDXW  = $clog2(NB);
  localparam logic [IDXW-1:0] LAST  = IDXW'(NB - 1);
  localparam logic [7:0]      LEN_B = 8'(NPAY);

  state_e                    state_q;
  logic [IDXW-1:0]           idx_q;
  logic [N_WORDS*WORD_W-1:0] shadow_q;
  logic [7:0]                tx_data_q;
  logic                      tx_en_q, busy_q, done_q, overrun_q;

  logic [NPAY-1:0][7:0] pay;
  logic [7:0]           byte_sel, chk;
  logic                 strobe, chk_en, chk_clr;

  // Payload byte g: word g/BPW, most significant byte of each word first.
  for (genvar g = 0; g < NPAY; g++) begin : g_pay
    assign pay[g] = shadow_q[(g / BPW) * WORD_W + (BPW - 1 - g % BPW) * 8 +: 8];
  end

  always_comb begin
    byte_sel = chk;
    if (idx_q == '0)               byte_sel = SYNC_BYTE;
    else if (idx_q == IDXW'(1))    byte_sel = LEN_B;
    for (int i = 0; i < NPAY; i++)
      if (idx_q == IDXW'(i + 2))   byte_sel = pay[i];
  end

  // SYNC and the CHK byte itself are kept out of the accumulation.
  assign strobe  = (state_q == SEND) && tx_ready;
  assign chk_en  = strobe && (idx_q != '0) && (idx_q != LAST);
  assign chk_clr = (state_q == IDLE) && start;

  uart_frame_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .clr    (chk_clr),
    .en     (chk_en),
    .byte_i (byte_sel),
    .chk_o  (chk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= start && (state_q != IDLE);
      case (state_q)
        IDLE: if (start) begin
          shadow_q <= words_in;
          idx_q    <= '0;
          busy_q   <= 1'b1;
          state_q  <= SEND;
        end
        SEND: if (tx_ready) begin
          tx_data_q <= byte_sel;
          tx_en_q   <= 1'b1;
          state_q   <= GAP;
        end
        // Transmitter ready drops during the strobe; skip one cycle before re-sampling it.
        GAP: state_q <= WAIT;
        WAIT: if (tx_ready) begin
          if (idx_q == LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + IDXW'(1);
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
